// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock timeout and lock-stability qualification
// Optional FAULT state after MAX_RETRIES consecutive timeouts is built when PLL_SUP_FAULT_EN is defined.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 20,
  parameter int LOCK_TIMEOUT  = 20000,
  parameter int STABLE_CYCLES = 2000,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pll_locked,
  output logic       o_pll_rst,
  output logic       o_sys_rst_n,
  output logic       o_ready,
  output logic [7:0] o_relock_count,
  output logic       o_fault
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CMP = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = (MAX_CMP > 1) ? $clog2(MAX_CMP) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_ready;
  logic [7:0]       r_relock_count;
  logic             w_lock_s;

  // Raw LOCK is asynchronous to the reference clock; only the second stage is ever used.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lock_s = r_sync2;

`ifdef PLL_SUP_FAULT_EN
  localparam int RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  logic [RETRY_W-1:0] r_retry_cnt;
  logic               r_fault;
  logic               w_retry_last;

  assign w_retry_last = (r_retry_cnt == RETRY_LAST);
  assign o_fault      = r_fault;
`else
  assign o_fault = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_PLL_RST;
      r_cnt          <= '0;
      r_pll_rst      <= 1'b1;
      r_sys_rst_n    <= 1'b0;
      r_ready        <= 1'b0;
      r_relock_count <= 8'd0;
`ifdef PLL_SUP_FAULT_EN
      r_retry_cnt    <= '0;
      r_fault        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_PLL_RST: begin
          if (r_cnt == RST_LAST) begin
            r_state   <= S_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
`ifdef PLL_SUP_FAULT_EN
            if (w_retry_last) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state     <= S_PLL_RST;
              r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
            end
`else
            r_state <= S_PLL_RST;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_STABLE: begin
          // Any dropout, however short, throws away the qualification progress.
          if (!w_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_sys_rst_n <= 1'b1;
            r_ready     <= 1'b1;
`ifdef PLL_SUP_FAULT_EN
            r_retry_cnt <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RUN: begin
          if (!w_lock_s) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            if (r_relock_count != 8'hFF) begin
              r_relock_count <= r_relock_count + 8'd1;
            end
          end
        end

`ifdef PLL_SUP_FAULT_EN
        S_FAULT: begin
          r_pll_rst   <= 1'b1;
          r_sys_rst_n <= 1'b0;
          r_ready     <= 1'b0;
          r_fault     <= 1'b1;
        end
`endif

        default: begin
          r_state     <= S_PLL_RST;
          r_cnt       <= '0;
          r_pll_rst   <= 1'b1;
          r_sys_rst_n <= 1'b0;
          r_ready     <= 1'b0;
        end
      endcase
    end
  end

  assign o_pll_rst      = r_pll_rst;
  assign o_sys_rst_n    = r_sys_rst_n;
  assign o_ready        = r_ready;
  assign o_relock_count = r_relock_count;

endmodule
